// File: rtl/adder_bcd_display_if.sv
// Operand/result bundle for the BCD adder display unit.
// The master side drives operands and the load request; the slave side
// returns status, the binary magnitude and the 7-segment digit codes.
interface adder_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                cin;
    logic                mode;
    logic                load;
    logic                busy;
    logic                done;
    logic                neg;
    logic [WIDTH:0]      result;
    logic [7*DIGITS-1:0] hex;

    modport master (
        output a, b, cin, mode, load,
        input  busy, done, neg, result, hex
    );

    modport slave (
        input  a, b, cin, mode, load,
        output busy, done, neg, result, hex
    );
endinterface

// File: rtl/adder_bcd_display.sv
// Add/subtract unit with a double-dabble binary-to-BCD engine driving a
// multi-digit active-low 7-segment display. The top digit shows the sign;
// the rest show the magnitude, optionally with leading zeros blanked.
module adder_bcd_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic               clock,
    input logic               resetn,
    adder_bcd_display_if.slave bus
);

    // Number of decimal digits needed to show any value of 'bits' bits.
    function automatic int dec_digits(input int bits);
        longint unsigned v;
        int              n;
        v = (64'd1 << bits) - 64'd1;
        n = 1;
        v = v / 64'd10;
        while (v != 64'd0) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    localparam int RES_W       = WIDTH + 1;
    localparam int BCD_N       = DIGITS - 1;
    localparam int BCD_W       = 4 * BCD_N;
    localparam int SR_W        = BCD_W + RES_W;
    localparam int CNT_W       = $clog2(RES_W + 1);
    localparam int NEED_DIGITS = dec_digits(RES_W);

    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    generate
        if (DIGITS < NEED_DIGITS + 1) begin : g_bad_digits
            $error("adder_bcd_display: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SHIFT,
        S_DONE
    } state_t;

    // Digit value to active-low abcdefg segment pattern (bit 6 = a).
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_cin;
    logic                r_mode;
    logic [RES_W-1:0]    r_mag;
    logic                r_neg_n;
    logic [SR_W-1:0]     r_sr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_neg;
    logic [RES_W-1:0]    r_result;
    logic [7*DIGITS-1:0] r_hex;

    logic [RES_W-1:0]    w_a_ext;
    logic [RES_W-1:0]    w_b_ext;
    logic [RES_W-1:0]    w_sum;
    logic [RES_W-1:0]    w_sub_rhs;
    logic                w_lt;
    logic [RES_W-1:0]    w_diff;
    logic [RES_W-1:0]    w_mag_n;
    logic                w_neg_n;
    logic [SR_W-1:0]     w_adj;
    logic [7*DIGITS-1:0] w_hex;

    // Arithmetic on the captured operands. b+cin can reach 2^WIDTH, which
    // still fits the WIDTH+1 bit magnitude, so the borrow compare is exact.
    assign w_a_ext   = {1'b0, r_a};
    assign w_b_ext   = {1'b0, r_b};
    assign w_sum     = w_a_ext + w_b_ext + RES_W'(r_cin);
    assign w_sub_rhs = w_b_ext + RES_W'(r_cin);
    assign w_lt      = (w_a_ext < w_sub_rhs);
    assign w_diff    = w_lt ? (w_sub_rhs - w_a_ext) : (w_a_ext - w_sub_rhs);
    assign w_mag_n   = r_mode ? w_diff : w_sum;
    assign w_neg_n   = r_mode & w_lt;

    // Shift-add-3 correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin : p_adjust
        // NOTE: default assignment first so no path leaves w_adj unassigned (no latch).
        w_adj = r_sr;
        for (int i = 0; i < BCD_N; i++) begin
            if (r_sr[RES_W + 4*i +: 4] >= 4'd5) begin
                w_adj[RES_W + 4*i +: 4] = r_sr[RES_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment image of the finished conversion, scanning from the top
    // magnitude digit down so leading zeros can be blanked.
    always_comb begin : p_encode
        logic seen;
        w_hex = '1;
        seen  = 1'b0;
        for (int i = BCD_N - 1; i >= 0; i--) begin
            if (r_sr[RES_W + 4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (BLANK_LZ && !seen && (i != 0)) begin
                w_hex[7*i +: 7] = SEG_BLANK;
            end else begin
                w_hex[7*i +: 7] = seg7(r_sr[RES_W + 4*i +: 4]);
            end
        end
        w_hex[7*(DIGITS-1) +: 7] = r_neg_n ? SEG_MINUS : SEG_BLANK;
    end

    // Control FSM plus datapath registers; visible outputs change only in DONE.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_mode   <= 1'b0;
            r_mag    <= '0;
            r_neg_n  <= 1'b0;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_hex    <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cin   <= bus.cin;
                        r_mode  <= bus.mode;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_mag   <= w_mag_n;
                    r_neg_n <= w_neg_n;
                    r_sr    <= {BCD_W'(0), w_mag_n};
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_sr <= w_adj << 1;
                    if (r_cnt == CNT_W'(RES_W - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_result <= r_mag;
                    r_neg    <= r_neg_n;
                    r_hex    <= w_hex;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.neg    = r_neg;
    assign bus.result = r_result;
    assign bus.hex    = r_hex;

endmodule

// File: tb/tb_adder_bcd_display.sv
// Scoreboard bench for adder_bcd_display: two instances (leading-zero
// blanking on and off) share the same operands; expected results are
// queued when a load is driven and compared when done pulses.
module tb_adder_bcd_display;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH + 3;
    localparam logic [27:0] ALL_BLANK = 28'hFFF_FFFF;

    typedef struct {
        int unsigned mag;
        bit          neg;
        logic [27:0] hex;
        logic [27:0] hex_nolz;
        int          due;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   checks   = 0;
    int   failures = 0;
    int unsigned last_mag = 0;
    exp_t sb[$];

    logic [6:0] seg_tab [10];

    adder_bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();
    adder_bcd_display_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus2 ();

    adder_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    adder_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) u_dut_nolz (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus2.slave)
    );

    assign bus2.a    = bus.a;
    assign bus2.b    = bus.b;
    assign bus2.cin  = bus.cin;
    assign bus2.mode = bus.mode;
    assign bus2.load = bus.load;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [27:0] model_hex(input int unsigned mag, input bit neg, input bit blz);
        logic [27:0] h;
        int unsigned d0, d1, d2;
        d0 = mag % 10;
        d1 = (mag / 10) % 10;
        d2 = (mag / 100) % 10;
        h[6:0]   = seg_tab[d0];
        h[13:7]  = (blz && mag < 10)  ? 7'b1111111 : seg_tab[d1];
        h[20:14] = (blz && mag < 100) ? 7'b1111111 : seg_tab[d2];
        h[27:21] = neg ? 7'b1111110 : 7'b1111111;
        return h;
    endfunction

    // Drive one load at the current negedge and queue its expected outcome.
    task automatic drive_op(input int a, input int b, input bit cin, input bit mode);
        exp_t e;
        int   d;
        bus.a    = WIDTH'(a);
        bus.b    = WIDTH'(b);
        bus.cin  = cin;
        bus.mode = mode;
        bus.load = 1'b1;
        e.neg = 1'b0;
        if (!mode) begin
            d = a + b + int'(cin);
        end else begin
            d = a - b - int'(cin);
            e.neg = (d < 0);
            if (d < 0) d = -d;
        end
        e.mag      = d;
        e.hex      = model_hex(e.mag, e.neg, 1'b1);
        e.hex_nolz = model_hex(e.mag, e.neg, 1'b0);
        e.due      = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clock);
        bus.load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    // Scoreboard consumer: compare every done pulse against the queue head.
    always @(negedge clock) begin : p_monitor
        exp_t e;
        if (resetn && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", bus.done, 1'b0);
            end else begin
                e = sb.pop_front();
                check("result",    bus.result, e.mag);
                check("neg",       bus.neg, e.neg);
                check("hex",       bus.hex, e.hex);
                check("hex_nolz",  bus2.hex, e.hex_nolz);
                check("done_nolz", bus2.done, 1'b1);
                check("latency",   cyc, e.due);
                check("busy_in_done", bus.busy, 1'b0);
                last_mag = e.mag;
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int ta [8] = '{200, 5, 255, 0,   0, 100, 10, 123};
        int tb [8] = '{55,  9, 255, 255, 0, 37,  10, 200};
        bit tc [8] = '{1,   0, 1,   1,   0, 0,   1,  1};
        bit tm [8] = '{0,   1, 0,   1,   0, 1,   1,  1};

        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.mode = 1'b0; bus.load = 1'b0;

        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_hex",      bus.hex, ALL_BLANK);
        check("rst_hex_nolz", bus2.hex, ALL_BLANK);
        check("rst_busy",     bus.busy, 1'b0);
        check("rst_done",     bus.done, 1'b0);
        check("rst_result",   bus.result, 0);
        check("rst_neg",      bus.neg, 1'b0);
        resetn = 1'b1;
        @(negedge clock);

        // Directed operations including the extremes
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            drive_op(ta[i], tb[i], tc[i], tm[i]);
            wait_idle(40);
        end

        // Random operations
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            drive_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(40);
        end

        // Load while busy is ignored; outputs hold during the conversion
        @(negedge clock);
        drive_op(1, 2, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("busy_mid",    bus.busy, 1'b1);
        check("hold_result", bus.result, last_mag);
        bus.a = 8'd50; bus.b = 8'd50; bus.load = 1'b1;
        @(negedge clock);
        bus.load = 1'b0;
        wait_idle(40);
        repeat (15) @(negedge clock);

        // Back-to-back: load presented in the done cycle
        @(negedge clock);
        drive_op(12, 34, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done) break;
        end
        check("b2b_done_seen", bus.done, 1'b1);
        drive_op(99, 1, 1'b1, 1'b1);
        wait_idle(40);

        // Reset in the middle of SHIFT aborts the conversion
        @(negedge clock);
        bus.a = 8'd77; bus.b = 8'd22; bus.cin = 1'b0; bus.mode = 1'b0; bus.load = 1'b1;
        @(negedge clock);
        bus.load = 1'b0;
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_hex",    bus.hex, ALL_BLANK);
        check("midrst_busy",   bus.busy, 1'b0);
        check("midrst_done",   bus.done, 1'b0);
        check("midrst_result", bus.result, 0);
        check("midrst_neg",    bus.neg, 1'b0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (15) @(negedge clock);
        @(negedge clock);
        drive_op(7, 8, 1'b0, 1'b1);
        wait_idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
